// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART ALU packet sequencer.
// Opcodes and header size match the host-side packet format.
package uart_alu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ECHO,
    OPER,
    RESULT,
    DRAIN
  } state_e;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_XOR  = 8'hA1;

  localparam logic [15:0] HDR_BYTES = 16'd4;

endpackage

// File: rtl/uart_alu_ctrl.sv
// Packet sequencer between UART RX and TX: parses a 4-byte header,
// then echoes the payload or streams a 32-bit ADD/XOR result.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
  localparam bit TMO_ON = (TIMEOUT_CYCLES != 0);

  state_e      state;
  logic [7:0]  opcode;
  logic [15:0] len;
  logic [15:0] cnt;
  logic [31:0] acc;
  logic [23:0] word;
  logic [31:0] timer;
  logic [1:0]  res_idx;
  logic        rdy_en;

  logic        rx_fire;
  logic        tx_fire;
  logic [15:0] cnt_nx;
  logic        last;
  logic [15:0] len_hdr;
  logic [31:0] word_nx;
  logic [31:0] acc_nx;
  logic [1:0]  res_idx_nx;
  logic        is_alu;
  logic        waiting;
  logic        tmo;

  assign rx_fire    = rx_valid_i & rx_ready_o;
  assign tx_fire    = tx_valid_o & tx_ready_i;
  assign cnt_nx     = cnt + 16'd1;
  assign last       = (cnt_nx == len);
  assign len_hdr    = {rx_data_i, len[7:0]};
  assign word_nx    = {rx_data_i, word};
  assign acc_nx     = (opcode == OP_ADD) ? acc + word_nx
                                         : acc ^ word_nx;
  assign res_idx_nx = res_idx + 2'd1;
  assign is_alu     = (opcode == OP_ADD) || (opcode == OP_XOR);
  assign busy_o     = (state != IDLE);

  // ECHO only waits on RX while no byte is pending on TX
  assign waiting = (state == HDR) || (state == OPER) ||
                   (state == DRAIN) ||
                   (state == ECHO && !tx_valid_o);
  assign tmo = TMO_ON && waiting && !rx_fire &&
               (timer == TMO_LAST);

  // rdy_en keeps rx_ready_o low while reset is held
  always_comb begin
    rx_ready_o = 1'b0;
    if (rdy_en) begin
      unique case (state)
        IDLE, HDR, OPER, DRAIN: rx_ready_o = 1'b1;
        ECHO:                   rx_ready_o = !tx_valid_o;
        default:                rx_ready_o = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      opcode     <= '0;
      len        <= '0;
      cnt        <= '0;
      acc        <= '0;
      word       <= '0;
      timer      <= '0;
      res_idx    <= '0;
      rdy_en     <= 1'b0;
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      timer  <= (waiting && !rx_fire) ? timer + 32'd1 : '0;
      if (tmo) begin
        state      <= IDLE;
        err_o      <= 1'b1;
        tx_valid_o <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (rx_fire) begin
            opcode <= rx_data_i;
            err_o  <= 1'b0;
            cnt    <= 16'd1;
            acc    <= '0;
            state  <= HDR;
          end
          HDR: if (rx_fire) begin
            cnt <= cnt_nx;
            if (cnt == 16'd2) len[7:0] <= rx_data_i;
            if (cnt == 16'd3) begin
              len[15:8] <= rx_data_i;
              if (len_hdr < HDR_BYTES) begin
                err_o <= 1'b1;
                state <= IDLE;
              end else if (len_hdr == HDR_BYTES) begin
                if (is_alu) begin
                  res_idx    <= '0;
                  tx_data_o  <= 8'h00;
                  tx_valid_o <= 1'b1;
                  state      <= RESULT;
                end else begin
                  err_o <= (opcode != OP_ECHO);
                  state <= IDLE;
                end
              end else if ((!is_alu && opcode != OP_ECHO) ||
                           (is_alu && len_hdr[1:0] != 2'd0)) begin
                err_o <= 1'b1;
                state <= DRAIN;
              end else begin
                state <= is_alu ? OPER : ECHO;
              end
            end
          end
          ECHO: begin
            if (rx_fire) begin
              tx_data_o  <= rx_data_i;
              tx_valid_o <= 1'b1;
              cnt        <= cnt_nx;
            end else if (tx_fire) begin
              tx_valid_o <= 1'b0;
              if (cnt == len) state <= IDLE;
            end
          end
          OPER: if (rx_fire) begin
            cnt  <= cnt_nx;
            word <= word_nx[31:8];
            if (cnt[1:0] == 2'd3) acc <= acc_nx;
            if (last) begin
              res_idx    <= '0;
              tx_data_o  <= acc_nx[7:0];
              tx_valid_o <= 1'b1;
              state      <= RESULT;
            end
          end
          RESULT: if (tx_fire) begin
            if (res_idx == 2'd3) begin
              tx_valid_o <= 1'b0;
              state      <= IDLE;
            end else begin
              res_idx   <= res_idx_nx;
              tx_data_o <= acc[{res_idx_nx, 3'b000} +: 8];
            end
          end
          DRAIN: if (rx_fire) begin
            cnt <= cnt_nx;
            if (last) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: directed packets plus random
// packets scored against a byte-level packet model.
module tb_uart_alu_ctrl;
  import uart_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data_i = '0;
  logic       rx_valid_i = 1'b0;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i = 1'b0;
  logic       busy_o;
  logic       err_o;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] tx_q[$];
  logic [7:0] pkt[$];
  logic [7:0] exp_q[$];
  bit         exp_err;
  bit         rdy_hold = 1'b0;

  uart_alu_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk),
    .rst(rst),
    .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .busy_o(busy_o),
    .err_o(err_o)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    if (!rdy_hold) tx_ready_i = ($urandom_range(0, 3) != 0);
  end

  initial forever begin
    @(posedge clk);
    if (rst && tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
  end

  // Packet-level reference: what TX should emit and whether err is raised
  task automatic model();
    logic [15:0] len;
    logic [31:0] acc;
    logic [31:0] w;
    exp_q.delete();
    exp_err = 1'b0;
    len = {pkt[3], pkt[2]};
    if (len < 4) exp_err = 1'b1;
    else if (pkt[0] == OP_ECHO) begin
      for (int i = 4; i < int'(len); i++) exp_q.push_back(pkt[i]);
    end else if ((pkt[0] == OP_ADD || pkt[0] == OP_XOR) && len % 4 == 0) begin
      acc = 0;
      for (int i = 4; i < int'(len); i += 4) begin
        w = {pkt[i+3], pkt[i+2], pkt[i+1], pkt[i]};
        acc = (pkt[0] == OP_ADD) ? acc + w : acc ^ w;
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(acc[i*8 +: 8]);
    end else exp_err = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    @(negedge clk);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (rx_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_accept byte %h: rx_ready=%b, required 1", b, rx_ready_o);
    end
    @(posedge clk);
    #1 rx_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while ((busy_o || tx_valid_o) && k < 500) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (busy_o !== 1'b0 || tx_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_wait: busy=%b tx_valid=%b, required 0 0", busy_o, tx_valid_o);
    end
  endtask

  task automatic send_pkt();
    tx_q.delete();
    foreach (pkt[i]) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(pkt[i]);
    end
    wait_idle();
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({tx_valid_o, tx_data_o, rx_ready_o, busy_o, err_o} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: v=%b d=%h rr=%b b=%b e=%b, required all 0",
               tx_valid_o, tx_data_o, rx_ready_o, busy_o, err_o);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if ({tx_valid_o, tx_data_o, rx_ready_o, busy_o, err_o} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_held: v=%b d=%h rr=%b b=%b e=%b, required all 0",
               tx_valid_o, tx_data_o, rx_ready_o, busy_o, err_o);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (rx_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: rx_ready=%b, required 1", rx_ready_o);
    end
  endtask

  task automatic test_echo();
    pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
    exp_q = '{8'h41, 8'h42};
    send_pkt();
    n_chk++;
    if (tx_q.size() != 2) begin
      n_fail++;
      $display("FAIL echo_count: got %0d, required 2", tx_q.size());
    end
    for (int i = 0; i < 2 && i < tx_q.size(); i++) begin
      n_chk++;
      if (tx_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL echo_byte%0d: got %h, required %h", i, tx_q[i], exp_q[i]);
      end
    end
    n_chk++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL echo_err: got %b, required 0", err_o);
    end
  endtask

  task automatic test_alu();
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: begin
          pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF};
          exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        end
        1: begin
          pkt = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF};
          exp_q = '{8'hFE, 8'hFF, 8'hFF, 8'hFF};
        end
        default: begin
          pkt = '{8'hA0, 8'h00, 8'h04, 8'h00};
          exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        end
      endcase
      send_pkt();
      n_chk++;
      if (tx_q.size() != 4) begin
        n_fail++;
        $display("FAIL alu%0d_count: got %0d, required 4", t, tx_q.size());
      end
      for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
        n_chk++;
        if (tx_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL alu%0d_byte%0d: got %h, required %h", t, i, tx_q[i], exp_q[i]);
        end
      end
      n_chk++;
      if (err_o !== 1'b0) begin
        n_fail++;
        $display("FAIL alu%0d_err: got %b, required 0", t, err_o);
      end
    end
  endtask

  task automatic test_errors();
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: begin
          pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
          exp_q = {};
          exp_err = 1'b1;
        end
        1: begin
          pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
          exp_q = '{8'h41, 8'h42};
          exp_err = 1'b0;
        end
        2: begin
          pkt = '{8'hEC, 8'h00, 8'h02, 8'h00};
          exp_q = {};
          exp_err = 1'b1;
        end
        default: begin
          pkt = '{8'hA0, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
          exp_q = {};
          exp_err = 1'b1;
        end
      endcase
      send_pkt();
      n_chk++;
      if (tx_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL err%0d_count: got %0d, required %0d", t, tx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
        n_chk++;
        if (tx_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL err%0d_byte%0d: got %h, required %h", t, i, tx_q[i], exp_q[i]);
        end
      end
      n_chk++;
      if (err_o !== exp_err) begin
        n_fail++;
        $display("FAIL err%0d_flag: got %b, required %b", t, err_o, exp_err);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b[3];
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    rdy_hold = 1'b1;
    tx_ready_i = 1'b1;
    tx_q.delete();
    send_byte(8'hEC);
    send_byte(8'h00);
    send_byte(8'h07);
    send_byte(8'h00);
    @(negedge clk);
    tx_ready_i = 1'b0;
    send_byte(b[0]);
    @(negedge clk);
    rx_data_i = b[1];
    rx_valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_chk++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== b[0] || rx_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: v=%b d=%h rr=%b, required 1 %h 0",
                 c, tx_valid_o, tx_data_o, rx_ready_o, b[0]);
      end
      @(negedge clk);
    end
    tx_ready_i = 1'b1;
    send_byte(b[1]);
    send_byte(b[2]);
    wait_idle();
    n_chk++;
    if (tx_q.size() != 3) begin
      n_fail++;
      $display("FAIL bp_count: got %0d, required 3", tx_q.size());
    end
    for (int i = 0; i < 3 && i < tx_q.size(); i++) begin
      n_chk++;
      if (tx_q[i] !== b[i]) begin
        n_fail++;
        $display("FAIL bp_byte%0d: got %h, required %h", i, tx_q[i], b[i]);
      end
    end
    rdy_hold = 1'b0;
  endtask

  task automatic test_random();
    int sel;
    int len;
    logic [7:0] op;
    for (int p = 0; p < 40; p++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        op = OP_ECHO;
        len = 4 + $urandom_range(0, 8);
      end else if (sel < 8) begin
        op = (sel < 6) ? OP_ADD : OP_XOR;
        len = 4 + 4 * $urandom_range(0, 4);
        if ($urandom_range(0, 4) == 0) len += $urandom_range(1, 3);
      end else if (sel == 8) begin
        op = 8'($urandom);
        while (op == OP_ECHO || op == OP_ADD || op == OP_XOR) op = 8'($urandom);
        len = 5 + $urandom_range(0, 5);
      end else begin
        op = OP_ECHO;
        len = $urandom_range(0, 3);
      end
      pkt = '{op, 8'($urandom), 8'(len), 8'(len >> 8)};
      for (int i = 4; i < len; i++) pkt.push_back(8'($urandom));
      model();
      send_pkt();
      n_chk++;
      if (tx_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rnd%0d_count op=%h len=%0d: got %0d, required %0d",
                 p, op, len, tx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
        n_chk++;
        if (tx_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rnd%0d_byte%0d op=%h: got %h, required %h",
                   p, i, op, tx_q[i], exp_q[i]);
        end
      end
      n_chk++;
      if (err_o !== exp_err) begin
        n_fail++;
        $display("FAIL rnd%0d_err op=%h len=%0d: got %b, required %b",
                 p, op, len, err_o, exp_err);
      end
    end
  endtask

  task automatic test_timeout();
    rdy_hold = 1'b1;
    tx_ready_i = 1'b1;
    tx_q.delete();
    send_byte(8'hEC);
    send_byte(8'h00);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h41);
    repeat (99) @(negedge clk);
    n_chk++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_early: err=%b busy=%b, required 0 1", err_o, busy_o);
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || tx_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_fire: err=%b busy=%b v=%b, required 1 0 0",
               err_o, busy_o, tx_valid_o);
    end
    n_chk++;
    if (tx_q.size() != 1 || (tx_q.size() == 1 && tx_q[0] !== 8'h41)) begin
      n_fail++;
      $display("FAIL tmo_echo: got %0d bytes, required 1 byte 41", tx_q.size());
    end
    rdy_hold = 1'b0;
  endtask

  task automatic test_reset_mid_result();
    rdy_hold = 1'b1;
    tx_ready_i = 1'b0;
    send_byte(8'hA0);
    send_byte(8'h00);
    send_byte(8'h08);
    send_byte(8'h00);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    @(negedge clk);
    n_chk++;
    if (tx_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL result_pending: v=%b busy=%b, required 1 1", tx_valid_o, busy_o);
    end
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({tx_valid_o, tx_data_o, rx_ready_o, busy_o, err_o} !== 12'h0) begin
      n_fail++;
      $display("FAIL async_reset: v=%b d=%h rr=%b b=%b e=%b, required all 0",
               tx_valid_o, tx_data_o, rx_ready_o, busy_o, err_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rdy_hold = 1'b0;
  endtask

  initial begin
    test_reset();
    test_echo();
    test_alu();
    test_errors();
    test_backpressure();
    test_random();
    test_timeout();
    test_reset_mid_result();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
Packet sequencer between the UART receiver and the UART transmitter. It parses byte packets arriving from RX and executes ECHO, ADD32 or XOR32 on the payload. It streams the echo bytes or the 4-byte result to TX using valid/ready handshakes on both sides. It sits inside the UART ALU top and sequences the TX datapath that is currently driven directly from board inputs.

Parameters:
TIMEOUT_CYCLES, 25_000_000, idle cycles allowed mid-packet while waiting for an RX byte before abort; 0 disables the timeout.

Ports:
clk  input  1  system clock (25 MHz PLL output)
rst  input  1  asynchronous, active-low reset
rx_data_i  input  8  byte from UART RX
rx_valid_i  input  1  RX byte valid
rx_ready_o  output  1  controller accepts RX byte
tx_data_o  output  8  byte to UART TX
tx_valid_o  output  1  TX byte valid
tx_ready_i  input  1  TX accepts byte
busy_o  output  1  high in any state other than IDLE
err_o  output  1  sticky error flag

Behaviour:
- Transfer rule: a transfer occurs on a rising clk edge when valid and ready are both high. tx_data_o is registered, held stable while tx_valid_o=1, and tx_valid_o drops only after the transfer.
- Reset (rst=0, asynchronous): state=IDLE, all counters and the accumulator = 0. tx_valid_o=0, tx_data_o=0, rx_ready_o=0, busy_o=0, err_o=0. Reset mid-packet discards the packet, and tx_valid_o falls immediately.
- Packet format: byte0 = opcode; byte1 = reserved (ignored); byte2/byte3 = LEN, little-endian 16-bit, counting the total packet bytes including the 4-byte header.
- States:
  - IDLE: rx_ready_o=1. The first accepted byte latches the opcode, clears err_o, and moves to HDR.
  - HDR: rx_ready_o=1. Accepts bytes 1..3. After byte3, decode and branch:
    - LEN<4 -> set err_o, go to IDLE.
    - LEN==4 -> ECHO goes to IDLE with no output; ADD/XOR go to RESULT with acc=0.
    - Unknown opcode, or ADD/XOR with (LEN-4) mod 4 != 0 -> set err_o, go to DRAIN.
    - Otherwise ECHO -> ECHO; ADD/XOR -> OPER.
  - ECHO: rx_ready_o = !tx_valid_o, with no combinational path from tx_ready_i. Each accepted byte loads tx_data_o and sets tx_valid_o. After LEN-4 bytes have been accepted and the last TX transfer completes, go to IDLE.
  - OPER: rx_ready_o=1. Bytes assemble a 32-bit little-endian word. On the 4th byte: ADD gives acc = acc + word (mod 2^32); XOR gives acc = acc ^ word. After LEN-4 bytes, go to RESULT.
  - RESULT: rx_ready_o=0. Sends acc as 4 bytes, LSB first, each waiting on tx_ready_i, then goes to IDLE.
  - DRAIN: rx_ready_o=1. Discards LEN-4 bytes, then goes to IDLE. No TX activity.
- Byte counter: 16-bit, counts accepted bytes within the packet. Byte index 65535 is legal with no wrap.
- Timeout: active in HDR, OPER, ECHO-waiting-for-RX and DRAIN. The counter resets on every accepted RX byte. Reaching TIMEOUT_CYCLES sets err_o and forces IDLE, clearing any pending tx_valid_o.
- err_o holds until the first byte of the next packet is accepted, or until reset.
- Latency: the echo byte appears on tx_valid_o 1 cycle after the RX transfer. The first result byte is valid 1 cycle after the last operand byte, or 1 cycle after the header when LEN==4.

Decomposition:
- Package uart_alu_pkg:
  - state enum: IDLE, HDR, ECHO, OPER, RESULT, DRAIN
  - opcode constants: OP_ECHO=8'hEC, OP_ADD=8'hA0, OP_XOR=8'hA1
  - HDR_BYTES=4
- No sub-module is required: the byte-to-word assembler and accumulator stay inline.
- uart_alu_ctrl is instantiated between the RX and TX in the top.

Test Plan:
- ECHO: RX EC 00 06 00 41 42 -> TX 41, 42; busy_o then returns to 0; err_o=0.
- ADD wrap: RX A0 00 0C 00 01 00 00 00 FF FF FF FF -> TX 00 00 00 00. XOR with the same operands -> TX FE FF FF FF.
- ADD, LEN=4: RX A0 00 04 00 -> TX 00 00 00 00.
- Errors: RX 55 00 06 00 11 22 -> no TX, err_o=1. A following valid ECHO packet clears err_o and echoes correctly. RX EC 00 02 00 -> err_o=1, back to IDLE. RX A0 00 07 00 + 3 bytes -> drained, err_o=1.
- Backpressure: during ECHO, hold tx_ready_i=0 for 10 cycles -> tx_data_o stable, tx_valid_o=1, rx_ready_o=0 throughout. Release -> next byte accepted.
- Timeout and reset (TIMEOUT_CYCLES=100): send EC 00 08 00 41, then stall -> err_o=1 at cycle 100, IDLE. Assert rst mid-RESULT -> tx_valid_o=0 immediately, all outputs at reset values.
